// File: rtl/gcd_pkg.sv
// Shared types for the gcd unit: controller state encoding and default width.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } gcd_state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/subtractor.sv
// Datapath for the gcd unit: both wrapping differences of a pair of operands.
module subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_minus_b_o,
  output logic [WIDTH-1:0] b_minus_a_o
);

  assign a_minus_b_o = a_i - b_i;
  assign b_minus_a_o = b_i - a_i;

endmodule

// File: rtl/gcd_ctrl.sv
// Iterative GCD by repeated subtraction, one step per cycle, valid/ready on both sides.
// Optional GCD_ITER_COUNT_EN adds iter_o, the subtract-step count of the last operation.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_ITER_COUNT_EN
  output logic [WIDTH-1:0] iter_o,
`endif
  output logic [WIDTH-1:0] gcd_o
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] a_sub, b_sub;

  subtractor #(.WIDTH(WIDTH)) u_subtractor (
    .a_i         (a_q),
    .b_i         (b_q),
    .a_minus_b_o (a_sub),
    .b_minus_a_o (b_sub)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_i;
          b_d     = b_i;
          state_d = CALC;
        end
      end
      CALC: begin
        // Only the larger-minus-smaller difference is ever taken, so nothing wraps.
        if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = DONE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_sub;
        end else begin
          b_d = b_sub;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (state_q == IDLE && in_valid) begin
      iter_d = '0;
    end else if (state_q == CALC && b_q != '0 && a_q != '0 && a_q != b_q) begin
      iter_d = iter_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign iter_o = iter_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign gcd_o     = gcd_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl at WIDTH=8 against a division-based Euclid model.
module tb_gcd_ctrl;

  localparam int W = 8;
  localparam int MAX_WAIT = 600;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] gcd_o;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_o;
`endif

  int checks = 0;
  int errors = 0;

  gcd_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GCD_ITER_COUNT_EN
    .iter_o    (iter_o),
`endif
    .gcd_o     (gcd_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_gcd(input int a, input int b);
    int x, y, r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  // Subtraction steps equal the sum of Euclid quotients, less one for the final equal-pair exit.
  function automatic int ref_steps(input int a, input int b);
    int x, y, r, s;
    if (a == 0 || b == 0) return 0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    s = 0;
    while (y != 0) begin
      s += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    return s - 1;
  endfunction

  function automatic logic [W-1:0] read_iter();
`ifdef GCD_ITER_COUNT_EN
    return iter_o;
`else
    return '0;
`endif
  endfunction

  // Latency counts the handshake cycle as cycle 0; lat is the cycle index where out_valid is first seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       output logic [W-1:0] res, output int lat, output logic [W-1:0] it);
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout a=%0d b=%0d: out_valid still %b after %0d cycles, required 1", a, b, out_valid, lat);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    res = gcd_o;
    it = read_iter();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (gcd_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_gcd got %0d want 0", gcd_o); end
    checks++;
    if (read_iter() !== 8'd0) begin errors++; $display("[TB] FAIL reset_iter got %0d want 0", read_iter()); end
  endtask

  task automatic test_directed();
    logic [W-1:0] res, it;
    int lat;
    int ta[6] = '{12, 0, 37, 0, 255, 255};
    int tb_[6] = '{8, 37, 0, 0, 1, 255};
    for (int k = 0; k < 6; k++) begin
      do_op(W'(ta[k]), W'(tb_[k]), 0, res, lat, it);
      checks++;
      if (res !== W'(ref_gcd(ta[k], tb_[k]))) begin
        errors++;
        $display("[TB] FAIL directed_gcd(%0d,%0d) got %0d want %0d", ta[k], tb_[k], res, ref_gcd(ta[k], tb_[k]));
      end
      checks++;
      if (lat != ref_steps(ta[k], tb_[k]) + 2) begin
        errors++;
        $display("[TB] FAIL directed_latency(%0d,%0d) got %0d want %0d", ta[k], tb_[k], lat, ref_steps(ta[k], tb_[k]) + 2);
      end
`ifdef GCD_ITER_COUNT_EN
      checks++;
      if (it !== W'(ref_steps(ta[k], tb_[k]))) begin
        errors++;
        $display("[TB] FAIL directed_iter(%0d,%0d) got %0d want %0d", ta[k], tb_[k], it, ref_steps(ta[k], tb_[k]));
      end
`endif
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_after_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a_i = 8'd48;
    b_i = 8'd18;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != ref_steps(48, 18) + 2) begin
      errors++;
      $display("[TB] FAIL bp_latency got %0d want %0d (out_valid=%b)", lat, ref_steps(48, 18) + 2, out_valid);
    end
    a_i = 8'd99;
    b_i = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || gcd_o !== 8'd6) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d out_valid=%b in_ready=%b gcd=%0d want 1/0/6", i, out_valid, in_ready, gcd_o);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_idle_stays in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] res, it;
    int lat;
    a_i = 8'd255;
    b_i = 8'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_calc out_valid=%b in_ready=%b gcd=%0d want 0/1/0", out_valid, in_ready, gcd_o);
    end
    do_op(8'd21, 8'd14, 2, res, lat, it);
    checks++;
    if (res !== 8'd7 || lat != ref_steps(21, 14) + 2) begin
      errors++;
      $display("[TB] FAIL after_reset_gcd got %0d lat %0d want 7 lat %0d", res, lat, ref_steps(21, 14) + 2);
    end
    a_i = 8'd12;
    b_i = 8'd8;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_done out_valid=%b in_ready=%b gcd=%0d want 0/1/0", out_valid, in_ready, gcd_o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, it;
    int lat, stall, ai, bi;
    for (int k = 0; k < 100; k++) begin
      a = W'($urandom_range(0, 255));
      b = (k % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 255));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      ai = int'(a);
      bi = int'(b);
      do_op(a, b, stall, res, lat, it);
      checks++;
      if (res !== W'(ref_gcd(ai, bi))) begin
        errors++;
        $display("[TB] FAIL rand_gcd(%0d,%0d) got %0d want %0d", ai, bi, res, ref_gcd(ai, bi));
      end
      checks++;
      if (lat != ref_steps(ai, bi) + 2) begin
        errors++;
        $display("[TB] FAIL rand_latency(%0d,%0d) got %0d want %0d", ai, bi, lat, ref_steps(ai, bi) + 2);
      end
`ifdef GCD_ITER_COUNT_EN
      checks++;
      if (it !== W'(ref_steps(ai, bi)) || read_iter() !== W'(ref_steps(ai, bi))) begin
        errors++;
        $display("[TB] FAIL rand_iter(%0d,%0d) got %0d/%0d want %0d", ai, bi, it, read_iter(), ref_steps(ai, bi));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
- Iterative GCD engine built around the team's `subtractor` datapath (Euclid by repeated subtraction).
- Accepts an operand pair over a valid/ready handshake and sequences the subtractor one step per cycle until the operands converge.
- Returns the result over a valid/ready handshake.
- Top-level block of the gcd unit; instantiates exactly one `subtractor`.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a_i/b_i is valid.
- in_ready  output  1  block can accept operands.
- a_i  input  WIDTH  operand A, unsigned.
- b_i  input  WIDTH  operand B, unsigned.
- out_valid  output  1  gcd_o holds a valid result.
- out_ready  input  1  consumer accepts the result.
- gcd_o  output  WIDTH  result, unsigned.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, gcd_o=0, internal a_q/b_q=0. Reset wins over every other event, including mid-CALC and in DONE with out_ready high. The in-flight result is discarded.
- Subtractor wiring: the subtractor inputs are a_q/b_q.
  - a_sub = a_q - b_q mod 2^WIDTH.
  - b_sub = b_q - a_q mod 2^WIDTH.
  - The controller uses only the non-wrapping difference.
- FSM states: IDLE, CALC, DONE (enum in package).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_q<=a_i, b_q<=b_i, go to CALC. Otherwise stay.
- CALC, evaluated each cycle in priority order:
  1. b_q==0: gcd_o<=a_q, go to DONE. Covers gcd(x,0)=x and gcd(0,0)=0.
  2. a_q==0: gcd_o<=b_q, go to DONE.
  3. a_q==b_q: gcd_o<=a_q, go to DONE.
  4. a_q>b_q: a_q<=a_sub, stay in CALC.
  5. Otherwise: b_q<=b_sub, stay in CALC.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; gcd_o held stable until handshake.
  - On out_ready: go to IDLE and deassert out_valid next cycle.
  - No new operands are accepted in the same cycle as the result handshake.
- Latency: with N subtraction steps, out_valid rises N+2 cycles after the accept edge.
  - N+1 cycles in CALC, then registered entry into DONE.
  - Worst case is gcd(2^WIDTH-1, 1): N = 2^WIDTH-2.
- Throughput: one operation in flight; no overlap.
- Width rules:
  - All comparisons are unsigned and WIDTH-wide.
  - No subtraction ever wraps, because only the larger-minus-smaller result is taken.
- Output drive: out_valid and in_ready are decoded from state. gcd_o is registered.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- Defined:
  - Adds output port iter_o [WIDTH-1:0].
  - iter_o clears to 0 on accept and increments on every CALC subtract step (cases 4/5).
  - It is held through DONE and IDLE until the next accept.
  - Reset value 0.
  - The WIDTH-bit counter never overflows, since max N = 2^WIDTH-2.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gcd_pkg holds:
  - typedef enum logic [1:0] gcd_state_e {IDLE, CALC, DONE}.
  - localparam DEFAULT_WIDTH = 8.
- One sub-module: the existing `subtractor` #(WIDTH), instantiated once. Comparisons and muxing stay in gcd_ctrl.

Test Plan:
- Reset for 2 cycles, then release -> in_ready=1, out_valid=0, gcd_o=0.
- a_i=12, b_i=8, out_ready=1 -> gcd_o=4; out_valid rises 4 cycles after accept (N=2); iter_o=2 if enabled.
- Zero cases: (0,37) -> 37; (37,0) -> 37; (0,0) -> 0; each with out_valid 2 cycles after accept (N=0).
- Worst case (255,1) at WIDTH=8 -> gcd_o=1 after 254 steps; iter_o=254; (255,255) -> 255 with N=0.
- Backpressure: (48,18) with out_ready=0 for 10 cycles after out_valid -> gcd_o=6 held stable, in_ready=0, and a new in_valid is ignored; result completes on out_ready=1.
- Reset mid-CALC during (255,1) at step 50 -> next cycle IDLE, out_valid=0. A following (21,14) yields 7.
- Random: 100 pairs checked against a reference model, with random out_ready stalls.
